// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencer feeding a small fetch queue between instruction memory and decode.
// Ports: i_clk/i_rst (sync active-high), i_enable, o_imem_addr/i_imem_data (combinational memory),
//        i_redirect/i_redirect_pc (flush + jump), o_valid/i_ready/o_instr/o_pc (decode handshake),
//        o_halted (zero-word halt status).
// Optional feature: define IFU_HALT_ON_ZERO_EN to stop fetching on an all-zero instruction word.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_halted
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam logic [AW:0] DEPTH = (AW + 1)'(QUEUE_DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t        state;
    logic [31:0]   pc;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   q_pc    [QUEUE_DEPTH];
    logic [31:0]   q_instr [QUEUE_DEPTH];
    logic          pop, cand, push, zero_word;
    // A pop in the same cycle frees the slot a full queue needs for the push.
    assign pop  = (count != 0) && i_ready && !i_redirect;
    assign cand = (state == RUN) && !i_redirect && ((count < DEPTH) || pop);
`ifdef IFU_HALT_ON_ZERO_EN
    assign zero_word = (i_imem_data == 32'h0000_0000);
`else
    assign zero_word = 1'b0;
`endif
    assign push        = cand && !zero_word;
    assign o_imem_addr = {2'b00, pc[31:2]};
    assign o_valid     = (count != 0);
    assign o_instr     = q_instr[rd_ptr];
    assign o_pc        = q_pc[rd_ptr];
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (i_redirect) begin
            state  <= i_enable ? RUN : IDLE;
            pc     <= i_redirect_pc & ~32'h3;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                q_pc[wr_ptr]    <= pc;
                q_instr[wr_ptr] <= i_imem_data;
                wr_ptr          <= wr_ptr + 1'b1;
                pc              <= pc + 32'd4;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
            case (state)
                IDLE:    state <= i_enable ? RUN : IDLE;
                RUN:     state <= !i_enable ? IDLE : (cand && zero_word) ? HALT : RUN;
                default: state <= HALT;
            endcase
        end
    end
`ifdef IFU_HALT_ON_ZERO_EN
    logic halted;
    always_ff @(posedge i_clk) begin
        if (i_rst || i_redirect)
            halted <= 1'b0;
        else if (cand && zero_word && i_enable)
            halted <= 1'b1;
    end
    assign o_halted = halted;
`else
    assign o_halted = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit against a 32-word combinational memory.
module tb_instr_fetch_unit;
    logic        i_clk, i_rst, i_enable, i_redirect, i_ready;
    logic [31:0] o_imem_addr, i_imem_data, i_redirect_pc, o_instr, o_pc;
    logic        o_valid, o_halted;
    logic [31:0] mem [32];
    logic [63:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          used;

    instr_fetch_unit dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .o_imem_addr(o_imem_addr),
        .i_imem_data(i_imem_data), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_pc(o_pc), .o_halted(o_halted)
    );

    assign i_imem_data = mem[o_imem_addr % 32];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [63:0] entry(input logic [31:0] pc);
        return {pc, mem[(pc >> 2) % 32]};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_enable = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0; i_ready = 1'b1;
        tick(); tick();
        i_rst = 1'b0;
        exp_q.delete();
    endtask

    // Compares each accepted head against the scoreboard until it empties or the budget runs out.
    task automatic drain(input int max_cycles, output int n);
        logic [63:0] e;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            if (o_valid && i_ready && !i_redirect) begin
                e = exp_q.pop_front();
                checks++;
                if ({o_pc, o_instr} !== e) begin
                    errors++;
                    $display("FAIL scoreboard got pc=%h instr=%h expected pc=%h instr=%h", o_pc, o_instr, e[63:32], e[31:0]);
                end
            end
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout %0d entries left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", o_valid); end
        if (o_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h expected 0", o_instr); end
        if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h expected 0", o_pc); end
        if (o_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b expected 0", o_halted); end
        if (o_imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h expected 0", o_imem_addr); end
    endtask

    task automatic test_enable_latency();
        do_reset();
        i_enable = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL latency_n1_valid got %b expected 0", o_valid); end
        tick();
        checks += 3;
        if (o_valid !== 1'b1) begin errors++; $display("FAIL latency_n2_valid got %b expected 1", o_valid); end
        if (o_instr !== 32'h02328020) begin errors++; $display("FAIL latency_instr got %h expected 02328020", o_instr); end
        if (o_pc !== 32'h0) begin errors++; $display("FAIL latency_pc got %h expected 0", o_pc); end
        for (int p = 0; p < 16; p += 4) exp_q.push_back(entry(p));
        drain(20, used);
        checks++;
        if (used !== 4) begin errors++; $display("FAIL stream_rate got %0d cycles expected 4", used); end
    endtask

    task automatic test_backpressure();
        do_reset();
        i_ready = 1'b0; i_enable = 1'b1;
        repeat (4) tick();
        checks += 3;
        if (o_imem_addr !== 32'd2) begin errors++; $display("FAIL full_addr got %h expected 2", o_imem_addr); end
        if (o_pc !== 32'h0 || o_valid !== 1'b1) begin errors++; $display("FAIL full_head got pc=%h v=%b expected pc=0 v=1", o_pc, o_valid); end
        tick();
        if (o_pc !== 32'h0 || o_instr !== mem[0] || o_imem_addr !== 32'd2) begin
            errors++; $display("FAIL full_stable got pc=%h instr=%h addr=%h expected 0 %h 2", o_pc, o_instr, o_imem_addr, mem[0]);
        end
        for (int p = 0; p < 12; p += 4) exp_q.push_back(entry(p));
        i_ready = 1'b1;
        drain(10, used);
        checks++;
        if (used !== 3) begin errors++; $display("FAIL consecutive got %0d cycles expected 3", used); end
    endtask

    task automatic test_redirect();
        do_reset();
        i_ready = 1'b0; i_enable = 1'b1;
        repeat (4) tick();
        i_ready = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'h13;
        tick();
        i_redirect = 1'b0;
        checks += 2;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL redirect_flush got %b expected 0", o_valid); end
        if (o_imem_addr !== 32'd4) begin errors++; $display("FAIL redirect_addr got %h expected 4", o_imem_addr); end
        for (int p = 'h10; p < 'h1c; p += 4) exp_q.push_back(entry(p));
        drain(10, used);
        checks++;
        if (used !== 4) begin errors++; $display("FAIL redirect_latency got %0d cycles expected 4", used); end
    endtask

    task automatic test_zero_word();
        mem[1] = 32'h0;
        do_reset();
        i_enable = 1'b1;
`ifdef IFU_HALT_ON_ZERO_EN
        exp_q.push_back(entry(0));
        drain(10, used);
        tick(); tick();
        checks += 3;
        if (o_halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b expected 1", o_halted); end
        if (o_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got %b expected 0", o_valid); end
        if (o_imem_addr !== 32'd1) begin errors++; $display("FAIL halt_addr got %h expected 1", o_imem_addr); end
        i_redirect = 1'b1; i_redirect_pc = 32'h0;
        tick();
        i_redirect = 1'b0;
        checks++;
        if (o_halted !== 1'b0) begin errors++; $display("FAIL halt_clear got %b expected 0", o_halted); end
        exp_q.push_back(entry(0));
        drain(10, used);
`else
        for (int p = 0; p < 12; p += 4) exp_q.push_back(entry(p));
        drain(10, used);
        checks++;
        if (o_halted !== 1'b0) begin errors++; $display("FAIL nohalt_flag got %b expected 0", o_halted); end
`endif
        mem[1] = 32'h1000_0111;
    endtask

    task automatic test_wrap();
        do_reset();
        i_enable = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFF;
        tick();
        i_redirect = 1'b0;
        exp_q.push_back(entry(32'hFFFF_FFFC));
        exp_q.push_back(entry(32'h0));
        exp_q.push_back(entry(32'h4));
        drain(10, used);
        checks++;
        if (used !== 4) begin errors++; $display("FAIL wrap_latency got %0d cycles expected 4", used); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        i_ready = 1'b0; i_enable = 1'b1;
        repeat (4) tick();
        i_rst = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'h40;
        tick();
        i_rst = 1'b0; i_redirect = 1'b0; i_ready = 1'b1;
        checks += 4;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b expected 0", o_valid); end
        if (o_pc !== 32'h0) begin errors++; $display("FAIL midrst_pc got %h expected 0", o_pc); end
        if (o_instr !== 32'h0) begin errors++; $display("FAIL midrst_instr got %h expected 0", o_instr); end
        if (o_imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_addr got %h expected 0", o_imem_addr); end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle got %b expected 0", o_valid); end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h0) begin errors++; $display("FAIL midrst_restart got v=%b pc=%h expected 1 0", o_valid, o_pc); end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = 32'h1000_0000 | (k * 32'h111);
        mem[0] = 32'h02328020;
        test_reset();
        test_enable_latency();
        test_backpressure();
        test_redirect();
        test_zero_word();
        test_wrap();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
